// File: rtl/mcu_local_axil_wr_fsm.sv
// Writeback stage: drains AXI-Stream result beats into consecutive AXI-Lite word writes
// and reports done/error back to the global MCU FSM.
module mcu_local_axil_wr_fsm #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_STEP       = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int GLO_FSM_WIDTH   = 2,
  parameter int GLO_FSM_STR     = 0,
  parameter int GLO_FSM_ERR     = 2,
  parameter int GLO_FSM_END     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  input  logic [GLO_FSM_WIDTH-1:0]  glo_fsm_state,
  input  logic [ADDR_WIDTH-1:0]     addr_base,
  input  logic [ADDR_WIDTH:0]       addr_counter_max,
  output logic                      done,
  output logic                      error
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OUT_W = 4;
  localparam logic [ADDR_WIDTH-1:0]    STEP    = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [OUT_W-1:0]         MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [GLO_FSM_WIDTH-1:0] G_STR   = GLO_FSM_WIDTH'(GLO_FSM_STR);
  localparam logic [GLO_FSM_WIDTH-1:0] G_ERR   = GLO_FSM_WIDTH'(GLO_FSM_ERR);
  localparam logic [GLO_FSM_WIDTH-1:0] G_END   = GLO_FSM_WIDTH'(GLO_FSM_END);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        word_idx_q, word_idx_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic slot_empty;
  logic tready;
  logic accept;
  logic b_hs;
  logic b_dec;
  logic b_err;
  logic exp_last;
  logic active;

  assign slot_empty = !awvalid_q && !wvalid_q;
  assign tready     = (state_q == S_RUN) && slot_empty && (outstanding_q < MAX_OUT);
  assign accept     = s_axis_tvalid && tready;
  assign b_hs       = m_axil_bvalid && m_axil_bready;
  // Stray responses after an aborted run must not wrap the counter below zero.
  assign b_dec      = b_hs && (outstanding_q != '0);
  assign b_err      = b_hs && (m_axil_bresp != 2'b00);
  assign exp_last   = (word_idx_q == (count_q - CNT_W'(1)));
  assign active     = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_DONE);

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q && !m_axil_awready;
    wvalid_d      = wvalid_q && !m_axil_wready;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    word_idx_d    = word_idx_q;
    outstanding_d = outstanding_q;
    base_d        = base_q;
    count_d       = count_q;

    case ({accept, b_dec})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (accept) begin
      awvalid_d  = 1'b1;
      wvalid_d   = 1'b1;
      awaddr_d   = base_q + word_idx_q[ADDR_WIDTH-1:0] * STEP;
      wdata_d    = s_axis_tdata;
      word_idx_d = word_idx_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (glo_fsm_state == G_STR) begin
          base_d        = addr_base;
          count_d       = addr_counter_max;
          word_idx_d    = '0;
          outstanding_d = '0;
          state_d       = (addr_counter_max == '0) ? S_ERR : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (s_axis_tlast && exp_last) begin
            state_d = S_DRAIN;
          end else if (s_axis_tlast != exp_last) begin
            state_d = S_ERR;
          end
        end
      end
      S_DRAIN: begin
        if (slot_empty && (outstanding_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (glo_fsm_state == G_END) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        // A pending AW/W must finish first: valid is never withdrawn on the bus.
        if ((glo_fsm_state == G_ERR) && slot_empty) begin
          state_d       = S_IDLE;
          word_idx_d    = '0;
          outstanding_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (b_err && active) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      awaddr_q      <= '0;
      word_idx_q    <= '0;
      outstanding_q <= '0;
      base_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      awaddr_q      <= awaddr_d;
      word_idx_q    <= word_idx_d;
      outstanding_q <= outstanding_d;
      base_q        <= base_d;
      count_q       <= count_d;
    end
  end

  // Write data is only observed while wvalid is high, so it needs no reset.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign s_axis_tready  = tready;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = !rst;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);

endmodule

// File: tb/tb_mcu_local_axil_wr_fsm.sv
// Directed bench for mcu_local_axil_wr_fsm with a small AXI-Lite slave responder.
module tb_mcu_local_axil_wr_fsm;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int MO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid;
  logic          m_axil_awready = 1'b0;
  logic [DW-1:0] m_axil_wdata;
  logic [DW/8-1:0] m_axil_wstrb;
  logic          m_axil_wvalid;
  logic          m_axil_wready = 1'b0;
  logic [1:0]    m_axil_bresp = 2'b00;
  logic          m_axil_bvalid = 1'b0;
  logic          m_axil_bready;
  logic [1:0]    glo_fsm_state = 2'd1;
  logic [AW-1:0] addr_base = '0;
  logic [AW:0]   addr_counter_max = '0;
  logic          done;
  logic          error;

  mcu_local_axil_wr_fsm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_STEP(1), .MAX_OUTSTANDING(MO),
    .GLO_FSM_WIDTH(2), .GLO_FSM_STR(0), .GLO_FSM_ERR(2), .GLO_FSM_END(3)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready), .glo_fsm_state(glo_fsm_state),
    .addr_base(addr_base), .addr_counter_max(addr_counter_max),
    .done(done), .error(error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave responder knobs (written only by the test tasks)
  int aw_delay  = 0;
  int w_delay   = 0;
  bit b_enable  = 1'b1;
  int b_err_idx = -1;

  // Slave/monitor state (written only by the clocked blocks below)
  int aw_wait = 0;
  int w_wait  = 0;
  int b_cnt   = 0;
  int inflight = 0;
  int full_viol = 0;
  int outst_viol = 0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];

  function automatic int pending_b();
    int n;
    n = (aw_log.size() < w_log.size()) ? aw_log.size() : w_log.size();
    return n - b_cnt;
  endfunction

  always @(posedge clk) begin
    if (m_axil_awvalid && m_axil_awready) aw_log.push_back(m_axil_awaddr);
    if (m_axil_wvalid && m_axil_wready) w_log.push_back(m_axil_wdata);
    if (m_axil_bvalid && m_axil_bready) b_cnt <= b_cnt + 1;
    if (s_axis_tvalid && s_axis_tready) begin
      if (m_axil_awvalid || m_axil_wvalid) full_viol <= full_viol + 1;
      if (inflight >= MO) outst_viol <= outst_viol + 1;
    end
    inflight <= inflight + ((s_axis_tvalid && s_axis_tready) ? 1 : 0)
                         - ((m_axil_bvalid && m_axil_bready) ? 1 : 0);
  end

  always @(negedge clk) begin
    if (m_axil_awvalid) begin
      if (aw_wait >= aw_delay) m_axil_awready <= 1'b1;
      else begin
        m_axil_awready <= 1'b0;
        aw_wait <= aw_wait + 1;
      end
    end else begin
      m_axil_awready <= 1'b0;
      aw_wait <= 0;
    end
    if (m_axil_wvalid) begin
      if (w_wait >= w_delay) m_axil_wready <= 1'b1;
      else begin
        m_axil_wready <= 1'b0;
        w_wait <= w_wait + 1;
      end
    end else begin
      m_axil_wready <= 1'b0;
      w_wait <= 0;
    end
    if (b_enable && pending_b() > 0) begin
      m_axil_bvalid <= 1'b1;
      m_axil_bresp  <= (b_cnt == b_err_idx) ? 2'b10 : 2'b00;
    end else begin
      m_axil_bvalid <= 1'b0;
      m_axil_bresp  <= 2'b00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [AW-1:0] base, input logic [AW:0] cnt);
    glo_fsm_state    = 2'd0;
    addr_base        = base;
    addr_counter_max = cnt;
    tick();
    glo_fsm_state    = 2'd1;
  endtask

  task automatic send_stream(input int n, input logic [DW-1:0] d0, input int last_pos,
                             input bit stop_on_err);
    int w;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d0 + DW'(i);
      s_axis_tlast  = (i == last_pos);
      w = 0;
      while (!s_axis_tready && !(stop_on_err && error) && w < 50) begin
        tick();
        w++;
      end
      if (stop_on_err && error) break;
      if (w >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_tready_timeout: beat %0d never accepted, tready=%b required 1", i, s_axis_tready);
        break;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while (done !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, w);
    end
  endtask

  task automatic wait_quiet(input string name);
    int w = 0;
    while ((pending_b() != 0 || m_axil_awvalid || m_axil_wvalid) && w < 50) begin
      tick();
      w++;
    end
    n_tests++;
    if (pending_b() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d write responses left unaccepted, required 0", name, pending_b());
    end
  endtask

  task automatic end_op(input string name);
    glo_fsm_state = 2'd3;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_hold: done=%b required 1", name, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_clear: done=%b required 0", name, done);
    end
    glo_fsm_state = 2'd1;
  endtask

  task automatic recover(input string name);
    int w = 0;
    glo_fsm_state = 2'd2;
    while (error !== 1'b0 && w < 50) begin
      tick();
      w++;
    end
    n_tests++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_recover: error=%b required 0", name, error);
    end
    glo_fsm_state = 2'd1;
    wait_quiet({name, "_quiet"});
  endtask

  task automatic check_writes(input string name, input int a0, input int w0,
                              input logic [AW-1:0] base, input logic [DW-1:0] d0, input int n);
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    for (int i = 0; i < n; i++) begin
      ga = (a0 + i < aw_log.size()) ? aw_log[a0 + i] : 'x;
      gd = (w0 + i < w_log.size()) ? w_log[w0 + i] : 'x;
      n_tests++;
      if (ga !== base + AW'(i) || gd !== d0 + DW'(i)) begin
        n_fail++;
        $display("FAIL %s_write%0d: got addr %0h data %0h, required addr %0h data %0h",
                 name, i, ga, gd, base + AW'(i), d0 + DW'(i));
      end
    end
    n_tests++;
    if (aw_log.size() - a0 != n || w_log.size() - w0 != n) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d AW %0d W, required %0d each",
               name, aw_log.size() - a0, w_log.size() - w0, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({s_axis_tready, m_axil_awvalid, m_axil_wvalid, done, error, m_axil_bready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: tready/awv/wv/done/err/bready=%b required 000000",
               {s_axis_tready, m_axil_awvalid, m_axil_wvalid, done, error, m_axil_bready});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (m_axil_bready !== 1'b1 || m_axil_awaddr !== '0 || m_axil_awprot !== 3'b000 || m_axil_wstrb !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: bready=%b awaddr=%0h awprot=%b wstrb=%b required 1 0 000 11",
               m_axil_bready, m_axil_awaddr, m_axil_awprot, m_axil_wstrb);
    end
  endtask

  task automatic test_basic();
    int a0 = aw_log.size();
    int w0 = w_log.size();
    int b0 = b_cnt;
    start_op(32'h100, 33'd4);
    send_stream(4, 16'hA1, 3, 1'b0);
    wait_done("basic_done");
    n_tests++;
    if (b_cnt - b0 != 4) begin
      n_fail++;
      $display("FAIL basic_b_at_done: %0d responses when done rose, required 4", b_cnt - b0);
    end
    check_writes("basic", a0, w0, 32'h100, 16'hA1, 4);
    end_op("basic");
  endtask

  task automatic test_skew(input int ad, input int wd, input logic [AW-1:0] base);
    int a0 = aw_log.size();
    int w0 = w_log.size();
    int b0 = b_cnt;
    int fv0 = full_viol;
    aw_delay = ad;
    w_delay  = wd;
    start_op(base, 33'd3);
    send_stream(3, 16'h31, 2, 1'b0);
    wait_done("skew_done");
    n_tests++;
    if (b_cnt - b0 != 3 || full_viol != fv0) begin
      n_fail++;
      $display("FAIL skew_handshakes: got %0d responses %0d full-slot accepts, required 3 and 0",
               b_cnt - b0, full_viol - fv0);
    end
    check_writes("skew", a0, w0, base, 16'h31, 3);
    end_op("skew");
    aw_delay = 0;
    w_delay  = 0;
  endtask

  task automatic test_backpressure();
    int a0 = aw_log.size();
    int w0 = w_log.size();
    int ov0 = outst_viol;
    b_enable = 1'b0;
    start_op(32'h400, 33'd5);
    fork
      send_stream(5, 16'h41, 4, 1'b0);
      begin
        repeat (6) tick();
        n_tests++;
        if (s_axis_tready !== 1'b0 || aw_log.size() - a0 != 2) begin
          n_fail++;
          $display("FAIL bp_stall: tready=%b issued=%0d, required 0 and 2",
                   s_axis_tready, aw_log.size() - a0);
        end
        repeat (4) tick();
        b_enable = 1'b1;
      end
    join
    wait_done("bp_done");
    n_tests++;
    if (outst_viol != ov0) begin
      n_fail++;
      $display("FAIL bp_outstanding: %0d beats accepted over the limit, required 0", outst_viol - ov0);
    end
    check_writes("bp", a0, w0, 32'h400, 16'h41, 5);
    end_op("bp");
  endtask

  task automatic test_tlast_mismatch();
    start_op(32'h500, 33'd4);
    send_stream(2, 16'hB1, 1, 1'b0);
    n_tests++;
    if (error !== 1'b1 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_tlast: error=%b tready=%b required 1 0", error, s_axis_tready);
    end
    recover("early");
    start_op(32'h600, 33'd4);
    send_stream(3, 16'hC1, -1, 1'b0);
    n_tests++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL late_tlast_premature: error=%b after 3 beats required 0", error);
    end
    send_stream(1, 16'hC4, -1, 1'b0);
    n_tests++;
    if (error !== 1'b1 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL late_tlast: error=%b tready=%b required 1 0", error, s_axis_tready);
    end
    recover("late");
  endtask

  task automatic test_slave_err();
    int w = 0;
    int a0, w0;
    b_err_idx = b_cnt + 1;
    start_op(32'h700, 33'd4);
    send_stream(4, 16'hD1, 3, 1'b1);
    while (error !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_tests++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL slverr_error: error=%b required 1", error);
    end
    w = 0;
    while ((pending_b() != 0 || m_axil_awvalid || m_axil_wvalid) && w < 50) begin
      tick();
      w++;
    end
    n_tests++;
    if (pending_b() != 0 || error !== 1'b1 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_drain: pending=%0d error=%b tready=%b required 0 1 0",
               pending_b(), error, s_axis_tready);
    end
    b_err_idx = -1;
    recover("slverr");
    a0 = aw_log.size();
    w0 = w_log.size();
    start_op(32'h780, 33'd2);
    send_stream(2, 16'h71, 1, 1'b0);
    wait_done("slverr_restart_done");
    check_writes("slverr_restart", a0, w0, 32'h780, 16'h71, 2);
    end_op("slverr_restart");
  endtask

  task automatic test_zero_and_reset();
    int a0, w0;
    start_op(32'h800, 33'd0);
    n_tests++;
    if (error !== 1'b1 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: error=%b tready=%b required 1 0", error, s_axis_tready);
    end
    recover("zero");
    start_op(32'h900, 33'd4);
    send_stream(2, 16'hF1, -1, 1'b0);
    rst = 1'b1;
    tick();
    n_tests++;
    if ({s_axis_tready, m_axil_awvalid, m_axil_wvalid, done, error, m_axil_bready} !== 6'b0
        || m_axil_awaddr !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: tready/awv/wv/done/err/bready=%b awaddr=%0h required 000000 0",
               {s_axis_tready, m_axil_awvalid, m_axil_wvalid, done, error, m_axil_bready}, m_axil_awaddr);
    end
    rst = 1'b0;
    tick();
    wait_quiet("midrun_reset_quiet");
    a0 = aw_log.size();
    w0 = w_log.size();
    start_op(32'h900, 33'd2);
    send_stream(2, 16'h55, 1, 1'b0);
    wait_done("restart_done");
    check_writes("restart", a0, w0, 32'h900, 16'h55, 2);
    end_op("restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew(3, 0, 32'h200);
    test_skew(0, 3, 32'h300);
    test_backpressure();
    test_tlast_mismatch();
    test_slave_err();
    test_zero_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcu_local_axil_wr_fsm.md
Name: mcu_local_axil_wr_fsm

Overview:
- Downstream writeback stage of the MCU datapath. Consumes the AXI-Stream result beats produced by the local read/compute path and writes them to memory over an AXI-Lite write master, one beat per consecutive word address.
- Sequenced by the global MCU FSM.
- Reports completion (all write responses returned after the tlast beat) and error back to the global FSM.

Parameters:
- DATA_WIDTH, 16, stream and AXI-Lite data width in bits (multiple of 8).
- ADDR_WIDTH, 32, AXI-Lite address width.
- ADDR_STEP, 1, address increment per written word.
- MAX_OUTSTANDING, 4, maximum writes issued without a B response (1..15).
- GLO_FSM_WIDTH, 2, global FSM state width.
- GLO_FSM_STR, 0, global "start" encoding.
- GLO_FSM_ERR, 2, global "error" encoding.
- GLO_FSM_END, 3, global "end" encoding.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  result data
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when high with tvalid
- s_axis_tlast  in  1  final beat of the operation
- m_axil_awaddr  out  ADDR_WIDTH  write address
- m_axil_awprot  out  3  constant 3'b000
- m_axil_awvalid  out  1  write address valid
- m_axil_awready  in  1  write address ready
- m_axil_wdata  out  DATA_WIDTH  write data
- m_axil_wstrb  out  DATA_WIDTH/8  all ones
- m_axil_wvalid  out  1  write data valid
- m_axil_wready  in  1  write data ready
- m_axil_bresp  in  2  write response
- m_axil_bvalid  in  1  response valid
- m_axil_bready  out  1  response ready, constant 1 outside reset
- glo_fsm_state  in  GLO_FSM_WIDTH  global FSM state
- addr_base  in  ADDR_WIDTH  first write address, sampled at start
- addr_counter_max  in  ADDR_WIDTH+1  number of words expected, sampled at start
- done  out  1  operation complete, level
- error  out  1  error, level

Behaviour:
- Reset values:
  - State IDLE.
  - s_axis_tready, awvalid, wvalid, done and error all 0.
  - bready 0 during rst, 1 otherwise.
  - Word counter, outstanding counter and address register all 0.
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE:
  - When glo_fsm_state==GLO_FSM_STR, latch addr_base and addr_counter_max.
  - If the latched count is 0, go to ERR; otherwise go to RUN.
- Holding slot: a single slot holds {addr, data}. The slot is empty when neither awvalid nor wvalid is high.
- s_axis_tready = (state==RUN) && slot empty && outstanding < MAX_OUTSTANDING. The signal is combinational and has no dependency on tvalid.
- On beat acceptance:
  - Register awaddr = addr_base + word_idx*ADDR_STEP and wdata = tdata.
  - Assert awvalid and wvalid on the next cycle.
  - Increment word_idx and outstanding.
- awvalid and wvalid clear independently on their own handshake; either channel may complete first or both in the same cycle. Throughput is at most one beat per 2 cycles.
- outstanding decrements on bvalid&&bready. A simultaneous increment and decrement leaves it unchanged.
- tlast check, evaluated on each accepted beat:
  - Expected last: word_idx == count-1.
  - tlast=1 with expected last: go to DRAIN.
  - tlast=1 without expected last (early): go to ERR.
  - tlast=0 with expected last (late/missing): go to ERR.
- DRAIN: s_axis_tready=0. When the slot is empty and outstanding==0 (counting a B arriving this cycle), go to DONE.
- DONE: done=1. When glo_fsm_state==GLO_FSM_END, go to IDLE with done=0 the following cycle.
- ERR:
  - error=1 and s_axis_tready=0.
  - A pending AW/W is still completed, because valid is never withdrawn.
  - B responses are still accepted.
  - When glo_fsm_state==GLO_FSM_ERR, go to IDLE once the slot is empty; counters are cleared.
- Error entry from any active state: bresp!=2'b00 on a B handshake.
- Error has priority over all other transitions in the same cycle.
- rst mid-operation: immediate return to reset values. Valids drop; reset is global, so the interconnect is reset too.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- word_idx is ADDR_WIDTH+1 bits wide.

Test Plan:
- Basic write: base=0x100, count=4, beats 0xA1..0xA4 with tlast on the 4th; awready/wready always high; bresp OKAY.
  -> Writes 0x100..0x103 in order with matching data; done=1 after the 4th B; done clears one cycle after glo_fsm_state=END.
- Channel skew: awready delayed 3 cycles and wready immediate (then the reverse), count=3.
  -> Each write completes once, no beat accepted while the slot is full, done after 3 Bs.
- Backpressure: MAX_OUTSTANDING=2, bvalid withheld for 10 cycles, count=5.
  -> tready stays low after 2 issued writes until a B returns; final addresses base..base+4.
- tlast mismatch: count=4, tlast on beat 2 -> error=1 on the next cycle, tready=0. Separately, count=4 with no tlast on beat 4 -> error=1.
- Slave error: bresp=2'b10 on the 2nd response -> error=1, with the remaining in-flight B still accepted. glo_fsm_state=ERR -> IDLE; a new start with count=2 then completes normally.
- Zero count plus reset: start with addr_counter_max=0 -> error=1. Separately, rst asserted mid-RUN after 2 beats -> all outputs 0 next cycle, and a subsequent start begins at addr_base again.
